// File: rtl/uart_cmd_frame_parser.sv
// rtl/uart_cmd_frame_parser.sv - sync-hunting framed command parser with XOR checksum
// Optional inter-byte timeout (err_code 3) is built in when UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_frame_parser #(
   parameter int          SYNC_LEN       = 3,
   parameter logic [31:0] SYNC_PATTERN   = 32'h00F0E0D0,
   parameter int          MAX_PAYLOAD    = 8,
   parameter logic [7:0]  DUMP_OPCODE    = 8'h01,
   parameter int          TIMEOUT_CYCLES = 100000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [7:0]               rx_data,
   input  logic                     rx_valid,
   output logic                     cmd_valid,
   output logic [7:0]               cmd_opcode,
   output logic [7:0]               cmd_len,
   output logic [8*MAX_PAYLOAD-1:0] cmd_payload,
   output logic                     trigger_dump,
   output logic                     err_valid,
   output logic [1:0]               err_code
);
   typedef enum logic [2:0] {S_SYNC, S_OPCODE, S_LEN, S_PAYLOAD, S_CSUM} state_t;

   localparam logic [7:0] SYNC_FIRST = SYNC_PATTERN[8*SYNC_LEN-1 -: 8];

   state_t                   state_q;
   logic [1:0]               sync_idx_q;
   logic [7:0]               work_op_q;
   logic [7:0]               work_len_q;
   logic [7:0]               pay_idx_q;
   logic [7:0]               csum_q;
   logic [8*MAX_PAYLOAD-1:0] work_payload_q;
   logic                     cmd_valid_q;
   logic                     trigger_dump_q;
   logic                     err_valid_q;
   logic [1:0]               err_code_q;
   logic [7:0]               cmd_opcode_q;
   logic [7:0]               cmd_len_q;
   logic [8*MAX_PAYLOAD-1:0] cmd_payload_q;
   logic [7:0]               sync_byte;

   // Pattern byte expected at the current sync index, first-received byte stored highest.
   assign sync_byte = 8'(SYNC_PATTERN >> (8 * (SYNC_LEN - 1 - int'(sync_idx_q))));

`ifdef UART_CMD_TIMEOUT_EN
   localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);
   logic [TW-1:0] tmo_q;
   logic          idle;
   logic          tmo_hit;
   assign idle    = (state_q == S_SYNC) && (sync_idx_q == 2'd0);
   assign tmo_hit = !idle && !rx_valid && (tmo_q == TMO_LIMIT);
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= S_SYNC;
         sync_idx_q     <= 2'd0;
         work_op_q      <= 8'd0;
         work_len_q     <= 8'd0;
         pay_idx_q      <= 8'd0;
         csum_q         <= 8'd0;
         work_payload_q <= '0;
         cmd_valid_q    <= 1'b0;
         trigger_dump_q <= 1'b0;
         err_valid_q    <= 1'b0;
         err_code_q     <= 2'd0;
         cmd_opcode_q   <= 8'd0;
         cmd_len_q      <= 8'd0;
         cmd_payload_q  <= '0;
`ifdef UART_CMD_TIMEOUT_EN
         tmo_q          <= '0;
`endif
      end else begin
         cmd_valid_q    <= 1'b0;
         trigger_dump_q <= 1'b0;
         err_valid_q    <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
         if (rx_valid || idle)
            tmo_q <= '0;
         else if (tmo_q != TMO_LIMIT)
            tmo_q <= tmo_q + 1'b1;
`endif
         if (rx_valid) begin
            case (state_q)
               S_SYNC: begin
                  if (rx_data == sync_byte) begin
                     if (sync_idx_q == 2'(SYNC_LEN - 1)) begin
                        state_q    <= S_OPCODE;
                        sync_idx_q <= 2'd0;
                     end else begin
                        sync_idx_q <= sync_idx_q + 2'd1;
                     end
                  end else if (rx_data == SYNC_FIRST) begin
                     sync_idx_q <= 2'd1;
                  end else begin
                     sync_idx_q <= 2'd0;
                  end
               end
               S_OPCODE: begin
                  work_op_q      <= rx_data;
                  work_payload_q <= '0;
                  csum_q         <= rx_data;
                  state_q        <= S_LEN;
               end
               S_LEN: begin
                  if (rx_data > 8'(MAX_PAYLOAD)) begin
                     err_valid_q <= 1'b1;
                     err_code_q  <= 2'd1;
                     state_q     <= S_SYNC;
                     sync_idx_q  <= 2'd0;
                  end else begin
                     work_len_q <= rx_data;
                     csum_q     <= csum_q ^ rx_data;
                     pay_idx_q  <= 8'd0;
                     state_q    <= (rx_data == 8'd0) ? S_CSUM : S_PAYLOAD;
                  end
               end
               S_PAYLOAD: begin
                  for (int i = 0; i < MAX_PAYLOAD; i++)
                     if (pay_idx_q == 8'(i)) work_payload_q[8*i +: 8] <= rx_data;
                  csum_q    <= csum_q ^ rx_data;
                  pay_idx_q <= pay_idx_q + 8'd1;
                  if (pay_idx_q + 8'd1 == work_len_q) state_q <= S_CSUM;
               end
               S_CSUM: begin
                  if (rx_data == csum_q) begin
                     cmd_valid_q    <= 1'b1;
                     trigger_dump_q <= (work_op_q == DUMP_OPCODE);
                     cmd_opcode_q   <= work_op_q;
                     cmd_len_q      <= work_len_q;
                     cmd_payload_q  <= work_payload_q;
                  end else begin
                     err_valid_q <= 1'b1;
                     err_code_q  <= 2'd2;
                  end
                  state_q    <= S_SYNC;
                  sync_idx_q <= 2'd0;
               end
               default: begin
                  state_q    <= S_SYNC;
                  sync_idx_q <= 2'd0;
               end
            endcase
         end
`ifdef UART_CMD_TIMEOUT_EN
         else if (tmo_hit) begin
            err_valid_q <= 1'b1;
            err_code_q  <= 2'd3;
            state_q     <= S_SYNC;
            sync_idx_q  <= 2'd0;
         end
`endif
      end
   end

   assign cmd_valid    = cmd_valid_q;
   assign cmd_opcode   = cmd_opcode_q;
   assign cmd_len      = cmd_len_q;
   assign cmd_payload  = cmd_payload_q;
   assign trigger_dump = trigger_dump_q;
   assign err_valid    = err_valid_q;
   assign err_code     = err_code_q;
endmodule

// File: tb/tb_uart_cmd_frame_parser.sv
// tb/tb_uart_cmd_frame_parser.sv - randomized frame traffic checked against a stream-level model
module tb_uart_cmd_frame_parser;
   localparam int          SYNC_LEN = 3;
   localparam logic [31:0] PAT      = 32'h00F0E0D0;
   localparam int          MAXP     = 8;
   localparam logic [7:0]  DUMP     = 8'h01;
   localparam int          TMO      = 16;
`ifdef UART_CMD_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [7:0]        rx_data = 8'd0;
   logic              rx_valid = 1'b0;
   logic              cmd_valid;
   logic [7:0]        cmd_opcode;
   logic [7:0]        cmd_len;
   logic [8*MAXP-1:0] cmd_payload;
   logic              trigger_dump;
   logic              err_valid;
   logic [1:0]        err_code;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: sliding sync window while hunting, then a byte queue per frame body.
   bit         hunting;
   logic [7:0] window[$];
   logic [7:0] body[$];
   int         m_idle;
   logic       e_cmd_valid, e_trig, e_err_valid;
   logic [1:0] e_err_code;
   logic [7:0] e_op, e_len;
   logic [63:0] e_payload;

   uart_cmd_frame_parser #(
      .SYNC_LEN(SYNC_LEN), .SYNC_PATTERN(PAT), .MAX_PAYLOAD(MAXP),
      .DUMP_OPCODE(DUMP), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .cmd_valid(cmd_valid), .cmd_opcode(cmd_opcode), .cmd_len(cmd_len),
      .cmd_payload(cmd_payload), .trigger_dump(trigger_dump),
      .err_valid(err_valid), .err_code(err_code)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] pat_byte(input int i);
      logic [31:0] p;
      p = PAT >> (8 * (SYNC_LEN - 1 - i));
      return p[7:0];
   endfunction

   function automatic bit window_matches(input int j);
      bit ok;
      ok = (window.size() >= j);
      if (ok)
         for (int t = 0; t < j; t++)
            if (window[window.size() - j + t] != pat_byte(t)) ok = 1'b0;
      return ok;
   endfunction

   function automatic int hunt_partial();
      for (int j = SYNC_LEN - 1; j >= 1; j--)
         if (window_matches(j)) return j;
      return 0;
   endfunction

   function automatic void back_to_hunt();
      hunting = 1'b1;
      window.delete();
      body.delete();
   endfunction

   function automatic void model_reset();
      back_to_hunt();
      m_idle      = 0;
      e_cmd_valid = 1'b0;
      e_trig      = 1'b0;
      e_err_valid = 1'b0;
      e_err_code  = 2'd0;
      e_op        = 8'd0;
      e_len       = 8'd0;
      e_payload   = 64'd0;
   endfunction

   function automatic void model_step(input logic v, input logic [7:0] d);
      logic [7:0] x;
      int n;
      e_cmd_valid = 1'b0;
      e_trig      = 1'b0;
      e_err_valid = 1'b0;
      if (v) begin
         m_idle = 0;
         if (hunting) begin
            window.push_back(d);
            if (window.size() > SYNC_LEN) void'(window.pop_front());
            if (window_matches(SYNC_LEN)) begin
               hunting = 1'b0;
               window.delete();
               body.delete();
            end
         end else begin
            body.push_back(d);
            n = body.size();
            if (n == 2 && body[1] > MAXP) begin
               e_err_valid = 1'b1;
               e_err_code  = 2'd1;
               back_to_hunt();
            end else if (n >= 3 && n == int'(body[1]) + 3) begin
               x = 8'd0;
               for (int i = 0; i < n - 1; i++) x ^= body[i];
               if (x == body[n-1]) begin
                  e_cmd_valid = 1'b1;
                  e_trig      = (body[0] == DUMP);
                  e_op        = body[0];
                  e_len       = body[1];
                  e_payload   = 64'd0;
                  for (int i = 0; i < int'(body[1]); i++) e_payload[8*i +: 8] = body[2+i];
               end else begin
                  e_err_valid = 1'b1;
                  e_err_code  = 2'd2;
               end
               back_to_hunt();
            end
         end
      end else if (TMO_EN) begin
         if (!hunting || hunt_partial() > 0) begin
            m_idle++;
            if (m_idle == TMO + 1) begin
               e_err_valid = 1'b1;
               e_err_code  = 2'd3;
               back_to_hunt();
               m_idle = 0;
            end
         end else begin
            m_idle = 0;
         end
      end
   endfunction

   task automatic check_outputs();
      check_eq("cmd_valid", cmd_valid, e_cmd_valid);
      check_eq("trigger_dump", trigger_dump, e_trig);
      check_eq("err_valid", err_valid, e_err_valid);
      check_eq("err_code", err_code, e_err_code);
      check_eq("cmd_opcode", cmd_opcode, e_op);
      check_eq("cmd_len", cmd_len, e_len);
      check_eq("cmd_payload", cmd_payload, e_payload);
   endtask

   task automatic step(input logic v, input logic [7:0] d);
      rx_valid = v;
      rx_data  = d;
      model_step(v, d);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'd0;
      model_reset();
      @(negedge clk);
      check_outputs();
      rst_n = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int maxgap);
      repeat ($urandom_range(0, maxgap)) step(1'b0, 8'd0);
      step(1'b1, b);
   endtask

   task automatic send_bytes(input logic [63:0] v, input int n);
      for (int i = 0; i < n; i++) step(1'b1, v[8*(n-1-i) +: 8]);
   endtask

   initial begin
      logic [7:0] fq[$];
      logic [7:0] op, len8, x, b;
      int kind, cut;
      bit stop;

      model_reset();
      repeat (2) @(negedge clk);
      do_reset();
      check_eq("rst_outputs", {cmd_valid, trigger_dump, err_valid, err_code, cmd_opcode, cmd_len}, 64'd0);

      send_bytes(64'hF0E0D0010001, 6);
      check_eq("tp_dump_valid", {cmd_valid, trigger_dump}, 64'h3);
      send_bytes(64'hF0E0D02202AA55DF, 8);
      check_eq("tp_pay_accept", {cmd_valid, trigger_dump}, 64'h2);
      check_eq("tp_pay_data", cmd_payload, 64'h55AA);
      send_bytes(64'hF0E0D02202AA55DE, 8);
      check_eq("tp_csum_err", {err_valid, err_code}, 64'h6);
      check_eq("tp_csum_keep", {cmd_opcode, cmd_len, cmd_payload[15:0]}, 64'h220255AA);
      send_bytes(64'hF0E0D00509, 5);
      check_eq("tp_len_err", {err_valid, err_code}, 64'h5);
      send_bytes(64'hF0E0D0050005, 6);
      check_eq("tp_after_len_err", {cmd_valid, cmd_opcode, cmd_len}, 64'h10500);
      send_bytes(64'h33F0F0E0D0010001, 8);
      check_eq("tp_overlap", {cmd_valid, trigger_dump}, 64'h3);
      send_bytes(64'hF0E0D02202AA, 6);
      do_reset();
      send_bytes(64'hF0E0D0010001, 6);
      check_eq("tp_after_reset", {cmd_valid, cmd_opcode}, 64'h101);

      send_bytes(64'hF0E0D02202AA, 6);
      repeat (TMO) step(1'b0, 8'd0);
`ifdef UART_CMD_TIMEOUT_EN
      step(1'b0, 8'd0);
      check_eq("tmo_fire", {err_valid, err_code}, 64'h7);
      send_bytes(64'hF0E0D02202AA, 6);
      repeat (TMO) step(1'b0, 8'd0);
      send_bytes(64'h55DF, 2);
      check_eq("tmo_limit_byte_wins", {cmd_valid, err_valid}, 64'h2);
`else
      repeat (24) step(1'b0, 8'd0);
      send_bytes(64'h55DF, 2);
      check_eq("no_tmo_accept", {cmd_valid, err_valid}, 64'h2);
`endif

      for (int f = 0; f < 300; f++) begin
         kind = $urandom_range(0, 9);
         if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 4)) send_byte(8'($urandom_range(0, 255)), 2);
         fq.delete();
         for (int i = 0; i < SYNC_LEN; i++) fq.push_back(pat_byte(i));
         op   = ($urandom_range(0, 2) == 0) ? DUMP : 8'($urandom_range(0, 255));
         len8 = (kind == 0) ? 8'($urandom_range(MAXP + 1, 255)) : 8'($urandom_range(0, MAXP));
         fq.push_back(op);
         fq.push_back(len8);
         if (kind != 0) begin
            x = op ^ len8;
            for (int i = 0; i < int'(len8); i++) begin
               b = 8'($urandom_range(0, 255));
               fq.push_back(b);
               x ^= b;
            end
            if (kind == 1) x ^= 8'($urandom_range(1, 255));
            fq.push_back(x);
         end
         cut  = $urandom_range(1, fq.size() - 1);
         stop = 1'b0;
         for (int i = 0; i < fq.size(); i++) begin
            if (!stop) begin
               if (kind == 2 && i == cut) begin
                  do_reset();
                  stop = 1'b1;
               end else begin
                  if (kind == 3 && i == SYNC_LEN + 2) repeat (20) step(1'b0, 8'd0);
                  send_byte(fq[i], 3);
               end
            end
         end
      end

      rx_valid = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
